aco_pheromone_selector: RTL and testbench

//  Parametrised ACO output-port selector for one mesh router, fed by the routing-function stage.

---
 rtl/aco_pheromone_selector_pkg.sv | 29 ++
 rtl/aco_pheromone_selector_if.sv | 45 ++++
 rtl/aco_pheromone_selector_evap_scheduler.sv | 63 ++++++
 rtl/aco_pheromone_selector.sv | 168 ++++++++++++++++
 tb/tb_aco_pheromone_selector.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aco_pheromone_selector_pkg.sv
// Shared types and helpers for the ACO pheromone selector slice.
// Contents:
//   ph_t, dir_t, node_t  default-width typedefs (4x4 mesh, 5-port router)
//   evap_state_e         evaporation scheduler states
//   PH_UNEXPLORED        pheromone value marking a never-visited entry
//   dir_to_port()        direction index -> router port index (port 0 is local)
package noc_aco_pkg;

   localparam int unsigned X_NODES_DEF = 4;
   localparam int unsigned Y_NODES_DEF = 4;
   localparam int unsigned N_DEF       = 5;
   localparam int unsigned PH_W_DEF    = 4;

   localparam int unsigned PH_UNEXPLORED = 0;

   typedef logic [PH_W_DEF-1:0]                          ph_t;
   typedef logic [$clog2(N_DEF-1)-1:0]                   dir_t;
   typedef logic [$clog2(X_NODES_DEF*Y_NODES_DEF)-1:0]   node_t;

   typedef enum logic {
      EVAP_IDLE,
      EVAP_SCAN
   } evap_state_e;

   function automatic int unsigned dir_to_port(input int unsigned dir);
      return dir + 1;
   endfunction

endpackage

// File: rtl/aco_pheromone_selector_if.sv
// Per-channel selection / backward-ant bus of the ACO selector.
// master: routing-function stage (drives i_*, receives o_*)
// slave : aco_pheromone_selector
//   i_sel_valid/i_avail/i_avail_cnt/i_sel_dest  selection request per input channel
//   i_upd_valid/i_upd_dest/i_upd_dir/i_upd_delta backward-ant update per input channel
//   o_req_valid/o_output_req/o_sel_err          registered selection result
//   o_upd_drop                                  update lost to a same-row collision
//   o_evap_busy                                 evaporation scan in progress
interface aco_pheromone_selector_if #(
   parameter int unsigned N     = 5,
   parameter int unsigned M     = 4,
   parameter int unsigned NODES = 16,
   parameter int unsigned PH_W  = 4
);
   localparam int unsigned DIR_W  = $clog2(N-1);
   localparam int unsigned CNT_W  = $clog2(M+1);
   localparam int unsigned NODE_W = $clog2(NODES);

   logic [N-1:0]                        i_sel_valid;
   logic [N-1:0][M-1:0][DIR_W-1:0]      i_avail;
   logic [N-1:0][CNT_W-1:0]             i_avail_cnt;
   logic [N-1:0][NODE_W-1:0]            i_sel_dest;
   logic [N-1:0]                        i_upd_valid;
   logic [N-1:0][NODE_W-1:0]            i_upd_dest;
   logic [N-1:0][DIR_W-1:0]             i_upd_dir;
   logic [N-1:0][PH_W-1:0]              i_upd_delta;
   logic [N-1:0]                        o_req_valid;
   logic [N-1:0][N-1:0]                 o_output_req;
   logic [N-1:0]                        o_sel_err;
   logic [N-1:0]                        o_upd_drop;
   logic                                o_evap_busy;

   modport master (
      output i_sel_valid, i_avail, i_avail_cnt, i_sel_dest,
      output i_upd_valid, i_upd_dest, i_upd_dir, i_upd_delta,
      input  o_req_valid, o_output_req, o_sel_err, o_upd_drop, o_evap_busy
   );

   modport slave (
      input  i_sel_valid, i_avail, i_avail_cnt, i_sel_dest,
      input  i_upd_valid, i_upd_dest, i_upd_dir, i_upd_delta,
      output o_req_valid, o_output_req, o_sel_err, o_upd_drop, o_evap_busy
   );

endinterface

// File: rtl/aco_pheromone_selector_evap_scheduler.sv
// Evaporation scheduler: free-running period counter that launches a scan
// of all table rows, one row per cycle.
//   clk, reset  clock, synchronous active-high reset
//   evap_en     high while scanning; evap_row is the row to evaporate this cycle
//   evap_row    current scan row, 0..NODES-1
module aco_evap_scheduler
   import noc_aco_pkg::*;
#(
   parameter int unsigned NODES       = 16,
   parameter int unsigned EVAP_PERIOD = 256
)(
   input  logic                     clk,
   input  logic                     reset,
   output logic                     evap_en,
   output logic [$clog2(NODES)-1:0] evap_row
);
   localparam int unsigned CNT_W = $clog2(EVAP_PERIOD);
   localparam int unsigned ROW_W = $clog2(NODES);

   evap_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ROW_W-1:0] row_q, row_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EVAP_IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
      end
   end

   // Counter never pauses; EVAP_PERIOD > NODES guarantees a scan ends before the next wrap.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      cnt_d   = (cnt_q == CNT_W'(EVAP_PERIOD-1)) ? '0 : cnt_q + CNT_W'(1);
      case (state_q)
         EVAP_IDLE: begin
            if (cnt_q == CNT_W'(EVAP_PERIOD-1)) begin
               state_d = EVAP_SCAN;
               row_d   = '0;
            end
         end
         EVAP_SCAN: begin
            if (row_q == ROW_W'(NODES-1)) begin
               state_d = EVAP_IDLE;
               row_d   = '0;
            end else begin
               row_d   = row_q + ROW_W'(1);
            end
         end
         default: state_d = EVAP_IDLE;
      endcase
   end

   assign evap_en  = (state_q == EVAP_SCAN);
   assign evap_row = row_q;

endmodule

// File: rtl/aco_pheromone_selector.sv
// ACO output-port selector for one mesh router.
// Holds a pheromone table (NODES rows x N-1 direction columns). Per input
// channel it picks one output among the admissible directions (registered,
// 1-cycle latency), applies backward-ant reinforcement/penalty updates and
// lets aco_evap_scheduler decay the table periodically.
//   clk, reset  clock, synchronous active-high reset
//   bus         aco_pheromone_selector_if.slave (selection, update, status)
module aco_pheromone_selector
   import noc_aco_pkg::*;
#(
   parameter int unsigned X_NODES     = 4,
   parameter int unsigned Y_NODES     = 4,
   parameter int unsigned N           = 5,
   parameter int unsigned M           = 4,
   parameter int unsigned PH_W        = 4,
   parameter int unsigned PH_MAX      = 15,
   parameter int unsigned PH_MIN      = 1,
   parameter int unsigned EVAP_PERIOD = 256
)(
   input  logic                      clk,
   input  logic                      reset,
   aco_pheromone_selector_if.slave   bus
);
   localparam int unsigned NODES  = X_NODES * Y_NODES;
   localparam int unsigned DIR_W  = $clog2(N-1);
   localparam int unsigned CNT_W  = $clog2(M+1);
   localparam int unsigned NODE_W = $clog2(NODES);
   localparam int unsigned PW1    = PH_W + 1;

   logic [NODES-1:0][N-2:0][PH_W-1:0] ph_table, ph_table_d;
   logic [N-1:0][N-1:0]               sel_req_d;
   logic [N-1:0]                      sel_err_d;
   logic [N-1:0]                      upd_win, upd_drop_d;
   logic                              evap_en;
   logic [NODE_W-1:0]                 evap_row;

   aco_evap_scheduler #(
      .NODES       (NODES),
      .EVAP_PERIOD (EVAP_PERIOD)
   ) u_evap (
      .clk      (clk),
      .reset    (reset),
      .evap_en  (evap_en),
      .evap_row (evap_row)
   );

   assign bus.o_evap_busy = evap_en;

   function automatic logic [PH_W-1:0] ph_reinforce(input logic [PH_W-1:0] ph,
                                                    input logic [PH_W-1:0] delta);
      logic [PW1-1:0] s;
      s = {1'b0, ph} + {1'b0, delta};
      if (s > PW1'(PH_MAX)) s = PW1'(PH_MAX);
      if (s < PW1'(PH_MIN)) s = PW1'(PH_MIN);
      return s[PH_W-1:0];
   endfunction

   function automatic logic [PH_W-1:0] ph_penalise(input logic [PH_W-1:0] ph,
                                                   input logic [PH_W-1:0] delta);
      logic [PW1-1:0] h;
      logic [PW1-1:0] d;
      h = {2'b00, delta[PH_W-1:1]};
      d = {1'b0, ph} - h;
      if (ph == PH_W'(PH_UNEXPLORED)) return ph;
      if ({1'b0, ph} >= h + PW1'(PH_MIN)) return d[PH_W-1:0];
      return PH_W'(PH_MIN);
   endfunction

   // Selection: unexplored entry wins at once, else strict max (ties keep lowest index).
   always_comb begin
      logic [CNT_W-1:0] cnt_c;
      logic [DIR_W-1:0] pick, d;
      logic [PH_W-1:0]  best, v;
      logic             have, unexp;
      sel_req_d = '0;
      sel_err_d = '0;
      cnt_c = '0;
      pick  = '0;
      d     = '0;
      best  = '0;
      v     = '0;
      have  = 1'b0;
      unexp = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         cnt_c = (bus.i_avail_cnt[i] > CNT_W'(M)) ? CNT_W'(M) : bus.i_avail_cnt[i];
         pick  = '0;
         best  = '0;
         have  = 1'b0;
         unexp = 1'b0;
         for (int unsigned q = 0; q < M; q++) begin
            if (q < int'(cnt_c) && !unexp) begin
               d = bus.i_avail[i][q];
               v = ph_table[bus.i_sel_dest[i]][d];
               if (v == PH_W'(PH_UNEXPLORED)) begin
                  pick  = d;
                  unexp = 1'b1;
               end else if (!have || v > best) begin
                  pick = d;
                  best = v;
                  have = 1'b1;
               end
            end
         end
         if (bus.i_sel_valid[i]) begin
            if (cnt_c == '0) sel_err_d[i] = 1'b1;
            else             sel_req_d[i] = N'(1) << dir_to_port(int'(pick));
         end
      end
   end

   // Same-row collisions: lowest channel index owns the row.
   always_comb begin
      upd_win    = '0;
      upd_drop_d = '0;
      for (int unsigned i = 0; i < N; i++) begin
         upd_win[i] = bus.i_upd_valid[i];
         for (int unsigned j = 0; j < i; j++) begin
            if (bus.i_upd_valid[j] && bus.i_upd_dest[j] == bus.i_upd_dest[i])
               upd_win[i] = 1'b0;
         end
         upd_drop_d[i] = bus.i_upd_valid[i] & ~upd_win[i];
      end
   end

   // An update to the row under scan replaces that row's evaporation step.
   always_comb begin
      logic row_hit;
      row_hit    = 1'b0;
      ph_table_d = ph_table;
      for (int unsigned r = 0; r < NODES; r++) begin
         row_hit = 1'b0;
         for (int unsigned i = 0; i < N; i++) begin
            if (upd_win[i] && bus.i_upd_dest[i] == NODE_W'(r)) begin
               row_hit = 1'b1;
               for (int unsigned c = 0; c < N-1; c++) begin
                  if (c == int'(bus.i_upd_dir[i]))
                     ph_table_d[r][c] = ph_reinforce(ph_table[r][c], bus.i_upd_delta[i]);
                  else
                     ph_table_d[r][c] = ph_penalise(ph_table[r][c], bus.i_upd_delta[i]);
               end
            end
         end
         if (evap_en && evap_row == NODE_W'(r) && !row_hit) begin
            for (int unsigned c = 0; c < N-1; c++) begin
               if (ph_table[r][c] > PH_W'(PH_MIN))
                  ph_table_d[r][c] = ph_table[r][c] - PH_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ph_table         <= '0;
         bus.o_req_valid  <= '0;
         bus.o_output_req <= '0;
         bus.o_sel_err    <= '0;
         bus.o_upd_drop   <= '0;
      end else begin
         ph_table         <= ph_table_d;
         bus.o_req_valid  <= bus.i_sel_valid;
         bus.o_output_req <= sel_req_d;
         bus.o_sel_err    <= sel_err_d;
         bus.o_upd_drop   <= upd_drop_d;
      end
   end

endmodule

// File: tb/tb_aco_pheromone_selector.sv
// Self-checking bench for aco_pheromone_selector (4x4 mesh, N=5, EVAP_PERIOD=32).
// A reference model of the table and outputs is advanced on every clock and
// compared against the DUT on every falling edge; literal checks pin the model.
module tb_aco_pheromone_selector;
   import noc_aco_pkg::*;

   logic clk;
   logic reset;
   int   nvec;
   int   nerr;
   bit   armed;

   aco_pheromone_selector_if #(.N(5), .M(4), .NODES(16), .PH_W(4)) bus ();

   aco_pheromone_selector #(
      .X_NODES     (4),
      .Y_NODES     (4),
      .N           (5),
      .M           (4),
      .PH_W        (4),
      .PH_MAX      (15),
      .PH_MIN      (1),
      .EVAP_PERIOD (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int             mt [16][4];
   int             ecount;
   logic [4:0]     e_valid, e_err, e_drop;
   logic [4:0][4:0] e_req;
   logic           e_busy;

   initial begin
      for (int r = 0; r < 16; r++) for (int c = 0; c < 4; c++) mt[r][c] = 0;
      ecount = 0; e_valid = '0; e_err = '0; e_drop = '0; e_req = '0; e_busy = 1'b0;
   end

   always @(posedge clk) begin : model
      int nt [16][4];
      bit rowhit [16];
      logic [4:0] v_n, err_n, drop_n;
      logic [4:0][4:0] req_n;
      int e, per, ph, cnt, pick, best, ds, dr, h, s, row;
      bit dup;
      v_n = '0; err_n = '0; drop_n = '0; req_n = '0;
      for (int r = 0; r < 16; r++) begin
         rowhit[r] = 1'b0;
         for (int c = 0; c < 4; c++) nt[r][c] = reset ? 0 : mt[r][c];
      end
      if (reset) begin
         ecount <= 0;
         e_busy <= 1'b0;
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (bus.i_sel_valid[i]) begin
               v_n[i] = 1'b1;
               cnt = int'(bus.i_avail_cnt[i]);
               if (cnt > 4) cnt = 4;
               ds = int'(bus.i_sel_dest[i]);
               if (cnt == 0) err_n[i] = 1'b1;
               else begin
                  pick = -1;
                  for (int q = 0; q < cnt; q++)
                     if (pick < 0 && mt[ds][bus.i_avail[i][q]] == 0) pick = int'(bus.i_avail[i][q]);
                  if (pick < 0) begin
                     best = -1;
                     for (int q = 0; q < cnt; q++)
                        if (mt[ds][bus.i_avail[i][q]] > best) begin
                           best = mt[ds][bus.i_avail[i][q]];
                           pick = int'(bus.i_avail[i][q]);
                        end
                  end
                  req_n[i][pick+1] = 1'b1;
               end
            end
         end
         for (int i = 0; i < 5; i++) begin
            if (bus.i_upd_valid[i]) begin
               dup = 1'b0;
               for (int j = 0; j < i; j++)
                  if (bus.i_upd_valid[j] && bus.i_upd_dest[j] == bus.i_upd_dest[i]) dup = 1'b1;
               if (dup) drop_n[i] = 1'b1;
               else begin
                  ds = int'(bus.i_upd_dest[i]);
                  dr = int'(bus.i_upd_dir[i]);
                  h  = int'(bus.i_upd_delta[i]) / 2;
                  rowhit[ds] = 1'b1;
                  for (int c = 0; c < 4; c++) begin
                     ph = mt[ds][c];
                     if (c == dr) begin
                        s = ph + int'(bus.i_upd_delta[i]);
                        if (s > 15) s = 15;
                        if (s < 1) s = 1;
                        nt[ds][c] = s;
                     end else if (ph != 0) begin
                        s = ph - h;
                        if (s < 1) s = 1;
                        nt[ds][c] = s;
                     end
                  end
               end
            end
         end
         // Scan k (k>=1) starts on edge 32k; row r decays on edge 32k+1+r.
         e   = ecount + 1;
         per = e % 32;
         if (e >= 32 && per >= 1 && per <= 16) begin
            row = per - 1;
            if (!rowhit[row])
               for (int c = 0; c < 4; c++) if (nt[row][c] > 1) nt[row][c] = nt[row][c] - 1;
         end
         ecount <= e;
         e_busy <= (e >= 32) && (per <= 15);
      end
      e_valid <= v_n; e_err <= err_n; e_drop <= drop_n; e_req <= req_n;
      for (int r = 0; r < 16; r++) for (int c = 0; c < 4; c++) mt[r][c] <= nt[r][c];
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin : compare
      logic [40:0] act, exp;
      int bad_row;
      if (armed) begin
         act = {bus.o_req_valid, bus.o_output_req, bus.o_sel_err, bus.o_upd_drop, bus.o_evap_busy};
         exp = {e_valid, e_req, e_err, e_drop, e_busy};
         nvec++;
         if (act !== exp) begin
            nerr++;
            $display("FAIL outputs t=%0t: got valid=%b req=%h err=%b drop=%b busy=%b, want valid=%b req=%h err=%b drop=%b busy=%b",
                     $time, bus.o_req_valid, bus.o_output_req, bus.o_sel_err, bus.o_upd_drop, bus.o_evap_busy,
                     e_valid, e_req, e_err, e_drop, e_busy);
         end
         bad_row = -1;
         for (int r = 0; r < 16; r++)
            for (int c = 0; c < 4; c++)
               if (bad_row < 0 && int'(dut.ph_table[r][c]) != mt[r][c]) bad_row = r;
         nvec++;
         if (bad_row >= 0) begin
            nerr++;
            $display("FAIL table t=%0t row %0d: got {%0d,%0d,%0d,%0d} want {%0d,%0d,%0d,%0d}", $time, bad_row,
                     dut.ph_table[bad_row][0], dut.ph_table[bad_row][1], dut.ph_table[bad_row][2], dut.ph_table[bad_row][3],
                     mt[bad_row][0], mt[bad_row][1], mt[bad_row][2], mt[bad_row][3]);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check_pin(input string nm, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic check_row(input string nm, input int r, input int a, input int b, input int c, input int d);
      nvec++;
      if (mt[r][0] != a || mt[r][1] != b || mt[r][2] != c || mt[r][3] != d) begin
         nerr++;
         $display("FAIL %s model row%0d: got {%0d,%0d,%0d,%0d} want {%0d,%0d,%0d,%0d}", nm, r,
                  mt[r][0], mt[r][1], mt[r][2], mt[r][3], a, b, c, d);
      end
      nvec++;
      if (int'(dut.ph_table[r][0]) != a || int'(dut.ph_table[r][1]) != b ||
          int'(dut.ph_table[r][2]) != c || int'(dut.ph_table[r][3]) != d) begin
         nerr++;
         $display("FAIL %s dut row%0d: got {%0d,%0d,%0d,%0d} want {%0d,%0d,%0d,%0d}", nm, r,
                  dut.ph_table[r][0], dut.ph_table[r][1], dut.ph_table[r][2], dut.ph_table[r][3], a, b, c, d);
      end
   endtask

   task automatic clear_inputs();
      bus.i_sel_valid = '0; bus.i_avail = '0; bus.i_avail_cnt = '0; bus.i_sel_dest = '0;
      bus.i_upd_valid = '0; bus.i_upd_dest = '0; bus.i_upd_dir = '0; bus.i_upd_delta = '0;
   endtask

   task automatic cyc();
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic upd(input int ch, input int dest, input int dir, input int delta);
      bus.i_upd_valid[ch] = 1'b1;
      bus.i_upd_dest[ch]  = 4'(dest);
      bus.i_upd_dir[ch]   = 2'(dir);
      bus.i_upd_delta[ch] = 4'(delta);
   endtask

   task automatic sel(input int ch, input int dest, input int cnt, input int a0, input int a1, input int a2, input int a3);
      bus.i_sel_valid[ch]  = 1'b1;
      bus.i_sel_dest[ch]   = 4'(dest);
      bus.i_avail_cnt[ch]  = 3'(cnt);
      bus.i_avail[ch][0]   = 2'(a0);
      bus.i_avail[ch][1]   = 2'(a1);
      bus.i_avail[ch][2]   = 2'(a2);
      bus.i_avail[ch][3]   = 2'(a3);
   endtask

   // Fresh row: first nonzero column in one shot, the rest by delta-1 steps (no penalty).
   task automatic preload(input int dest, input int a, input int b, input int c, input int d);
      int v [4];
      bit first;
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      first = 1'b1;
      for (int col = 0; col < 4; col++) begin
         if (v[col] != 0) begin
            if (first) begin
               upd(0, dest, col, v[col]);
               cyc();
               first = 1'b0;
            end else begin
               for (int n = 0; n < v[col]; n++) begin
                  upd(0, dest, col, 1);
                  cyc();
               end
            end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      nvec = 0; nerr = 0; armed = 1'b0;
      reset = 1'b1;
      clear_inputs();
      @(negedge clk);
      do_reset();
      armed = 1'b1;
      check_pin("reset.valid", int'(bus.o_req_valid), 0);
      check_pin("reset.busy", int'(bus.o_evap_busy), 0);
      check_row("reset.row5", 5, 0, 0, 0, 0);

      // A: empty table, first admissible direction wins
      sel(1, 5, 2, 0, 2, 0, 0);
      cyc();
      check_pin("A.req1", int'(bus.o_output_req[1]), 5'b00010);
      check_pin("A.valid", int'(bus.o_req_valid), 5'b00010);

      // B: reinforce dir2 of row5; unexplored dir0 still wins
      do_reset();
      upd(2, 5, 2, 6);
      cyc();
      check_row("B.row5", 5, 0, 0, 6, 0);
      sel(1, 5, 2, 0, 2, 0, 0);
      sel(4, 9, 0, 1, 1, 1, 1);
      cyc();
      check_pin("B.req1", int'(bus.o_output_req[1]), 5'b00010);
      check_pin("B.err", int'(bus.o_sel_err), 5'b10000);
      check_pin("B.valid", int'(bus.o_req_valid), 5'b10010);
      check_pin("B.req4", int'(bus.o_output_req[4]), 0);
      sel(1, 5, 1, 2, 0, 0, 0);
      cyc();
      check_pin("B.req1.only2", int'(bus.o_output_req[1]), 5'b01000);

      // C: tie to lowest index, read sees pre-update state, then penalty
      do_reset();
      preload(5, 4, 9, 9, 4);
      check_row("C.preload", 5, 4, 9, 9, 4);
      sel(1, 5, 2, 1, 2, 0, 0);
      upd(0, 5, 1, 15);
      cyc();
      check_pin("C.tie", int'(bus.o_output_req[1]), 5'b00100);
      check_row("C.upd", 5, 1, 15, 2, 1);
      sel(2, 5, 3, 0, 2, 3, 0);
      sel(3, 5, 7, 3, 0, 1, 2);
      cyc();
      check_pin("C.max", int'(bus.o_output_req[2]), 5'b01000);
      check_pin("C.clamp", int'(bus.o_output_req[3]), 5'b00100);

      // D: same-row collision, different rows in parallel
      do_reset();
      upd(0, 7, 0, 3);
      upd(3, 7, 1, 5);
      upd(1, 2, 3, 4);
      cyc();
      check_pin("D.drop", int'(bus.o_upd_drop), 5'b01000);
      check_row("D.row7", 7, 3, 0, 0, 0);
      check_row("D.row2", 2, 0, 0, 0, 4);
      cyc();
      check_pin("D.drop.clear", int'(bus.o_upd_drop), 0);

      // E: evaporation timing and decay
      do_reset();
      upd(0, 3, 3, 15);
      cyc();
      for (int k = 0; k < 5; k++) begin upd(0, 3, 1, 1); cyc(); end
      upd(0, 3, 0, 1);
      cyc();
      check_row("E.pre", 3, 1, 5, 0, 15);
      repeat (24) cyc();
      check_pin("E.busy@31", int'(bus.o_evap_busy), 0);
      cyc();
      check_pin("E.busy@32", int'(bus.o_evap_busy), 1);
      n = 0;
      while (bus.o_evap_busy && n < 100) begin
         n++;
         cyc();
      end
      check_pin("E.busy_len", n, 16);
      check_row("E.decay", 3, 1, 4, 0, 14);

      // E2: update in the row's scan cycle overrides the decay; then reset mid-scan
      do_reset();
      preload(3, 1, 5, 0, 15);
      repeat (14) cyc();
      upd(1, 3, 3, 0);
      cyc();
      check_row("E2.upd_only", 3, 1, 5, 0, 15);
      repeat (4) cyc();
      check_pin("E2.busy", int'(bus.o_evap_busy), 1);
      reset = 1'b1;
      cyc();
      check_pin("E2.rst.busy", int'(bus.o_evap_busy), 0);
      check_row("E2.rst.row3", 3, 0, 0, 0, 0);
      reset = 1'b0;

      // Mixed traffic across a scan window, model-checked every cycle
      do_reset();
      for (int t = 0; t < 60; t++) begin
         for (int i = 0; i < 5; i++) begin
            bus.i_sel_valid[i] = ((t + i) % 3) != 0;
            bus.i_avail_cnt[i] = 3'((t + i) % 6);
            bus.i_sel_dest[i]  = 4'((t * 5 + i) % 16);
            for (int q = 0; q < 4; q++) bus.i_avail[i][q] = 2'((t * 7 + i * 3 + q) % 4);
            bus.i_upd_valid[i] = ((t + 2 * i) % 4) == 0;
            bus.i_upd_dest[i]  = 4'(((i % 2) == 0) ? ((t * 3) % 16) : ((t + i) % 16));
            bus.i_upd_dir[i]   = 2'((t + i) % 4);
            bus.i_upd_delta[i] = 4'((t * 3 + i) % 16);
         end
         cyc();
      end
      repeat (3) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
